rf_trace_collector: RTL and testbench

Multi-channel register-file write-event trace collector for the debug path of the scalar core. It generalises the single integer write-event trace port to NUM_CH channels, each carrying an int/float flag. Each cycle it captures up to NUM_CH events, tags them with PC and a cycle timestamp, and buffers them in a multi-push FIFO. The debugger drains the FIFO one event per cycle over a valid/ready stream, and lost events are counted.

---
 rtl/rf_trace_collector.sv | 133 +++++++++++++
 tb/tb_rf_trace_collector.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_trace_collector.sv
// Multi-channel register-file write-event trace collector with multi-push FIFO and drop counting.
// Optional build macro RF_TRACE_FILTER_X0_EN masks integer x0 writes before capture.
module rf_trace_collector #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int PC_W       = 32,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     capture_en_i,
  input  logic                     clear_i,
  input  logic [PC_W-1:0]          pc_i,
  input  logic [NUM_CH-1:0]        ev_en_i,
  input  logic [NUM_CH-1:0]        ev_fp_i,
  input  logic [NUM_CH*ADDR_W-1:0] ev_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] ev_data_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [DATA_W-1:0]        trace_data_o,
  output logic [ADDR_W-1:0]        trace_addr_o,
  output logic                     trace_fp_o,
  output logic [CH_W-1:0]          trace_ch_o,
  output logic [PC_W-1:0]          trace_pc_o,
  output logic [TS_W-1:0]          trace_ts_o,
  output logic [LVL_W-1:0]         level_o,
  output logic [15:0]              drop_cnt_o,
  output logic                     overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic              mem_fp   [FIFO_DEPTH];
  logic [CH_W-1:0]   mem_ch   [FIFO_DEPTH];
  logic [PC_W-1:0]   mem_pc   [FIFO_DEPTH];
  logic [TS_W-1:0]   mem_ts   [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [TS_W-1:0]   ts;
  logic [15:0]       drop_cnt;
  logic              overflow;

  logic [NUM_CH-1:0] ev_mask;
  logic [LVL_W-1:0]  n_ev;
  logic [LVL_W-1:0]  free_cnt;
  logic [PTR_W-1:0]  slot [NUM_CH];
  logic              valid, push, drop, pop;
  logic [16:0]       drop_sum;

  // Each enabled channel lands at wr_ptr plus the number of enabled channels below it.
  always_comb begin
    ev_mask = ev_en_i & {NUM_CH{capture_en_i}};
`ifdef RF_TRACE_FILTER_X0_EN
    for (int i = 0; i < NUM_CH; i++) begin
      if (!ev_fp_i[i] && (ev_addr_i[i*ADDR_W +: ADDR_W] == '0)) ev_mask[i] = 1'b0;
    end
`endif
    n_ev = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      slot[i] = wr_ptr + n_ev[PTR_W-1:0];
      n_ev    = n_ev + LVL_W'(ev_mask[i]);
    end
  end

  // Free space is taken before any same-cycle pop, so a full FIFO drops even while draining.
  assign free_cnt = LVL_W'(FIFO_DEPTH) - level;
  assign valid    = (level != '0);
  assign pop      = valid && trace_ready_i && !clear_i;
  assign push     = !clear_i && (n_ev != '0) && (n_ev <= free_cnt);
  assign drop     = !clear_i && (n_ev > free_cnt);
  assign drop_sum = {1'b0, drop_cnt} + 17'(n_ev);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ts       <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (clear_i) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        drop_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + n_ev[PTR_W-1:0];
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        level <= level + (push ? n_ev : '0) - LVL_W'(pop);
        if (drop) begin
          drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
          overflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push && ev_mask[i]) begin
        mem_data[slot[i]] <= ev_data_i[i*DATA_W +: DATA_W];
        mem_addr[slot[i]] <= ev_addr_i[i*ADDR_W +: ADDR_W];
        mem_fp[slot[i]]   <= ev_fp_i[i];
        mem_ch[slot[i]]   <= CH_W'(i);
        mem_pc[slot[i]]   <= pc_i;
        mem_ts[slot[i]]   <= ts;
      end
    end
  end

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign trace_valid_o = valid;
  assign trace_data_o  = valid ? mem_data[rd_ptr] : '0;
  assign trace_addr_o  = valid ? mem_addr[rd_ptr] : '0;
  assign trace_fp_o    = valid ? mem_fp[rd_ptr]   : 1'b0;
  assign trace_ch_o    = valid ? mem_ch[rd_ptr]   : '0;
  assign trace_pc_o    = valid ? mem_pc[rd_ptr]   : '0;
  assign trace_ts_o    = valid ? mem_ts[rd_ptr]   : '0;
  assign level_o       = level;
  assign drop_cnt_o    = drop_cnt;
  assign overflow_o    = overflow;

endmodule

// File: tb/tb_rf_trace_collector.sv
// Directed bench for rf_trace_collector: capture, ordering, drops, pre-pop free space, clear, x0 filter.
module tb_rf_trace_collector;

  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         capture_en_i = 1'b0;
  logic         clear_i = 1'b0;
  logic [31:0]  pc_i = '0;
  logic [3:0]   ev_en_i = '0;
  logic [3:0]   ev_fp_i = '0;
  logic [19:0]  ev_addr_i = '0;
  logic [255:0] ev_data_i = '0;
  logic         trace_valid_o;
  logic         trace_ready_i = 1'b0;
  logic [63:0]  trace_data_o;
  logic [4:0]   trace_addr_o;
  logic         trace_fp_o;
  logic [1:0]   trace_ch_o;
  logic [31:0]  trace_pc_o;
  logic [15:0]  trace_ts_o;
  logic [4:0]   level_o;
  logic [15:0]  drop_cnt_o;
  logic         overflow_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] tb_ts;
  logic [15:0] exp_ts;

  rf_trace_collector dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .capture_en_i(capture_en_i), .clear_i(clear_i),
    .pc_i(pc_i), .ev_en_i(ev_en_i), .ev_fp_i(ev_fp_i), .ev_addr_i(ev_addr_i),
    .ev_data_i(ev_data_i), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_data_o(trace_data_o), .trace_addr_o(trace_addr_o), .trace_fp_o(trace_fp_o),
    .trace_ch_o(trace_ch_o), .trace_pc_o(trace_pc_o), .trace_ts_o(trace_ts_o),
    .level_o(level_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference cycle counter: the value an event captured right now should carry.
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) tb_ts <= '0;
    else         tb_ts <= tb_ts + 16'd1;
  end

  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] en, input logic [3:0] fp,
                                input logic [31:0] pc, input logic [7:0] data_base);
    ev_en_i = en;
    ev_fp_i = fp;
    pc_i    = pc;
    for (int i = 0; i < 4; i++) begin
      ev_addr_i[i*5 +: 5]   = 5'(i + 1);
      ev_data_i[i*64 +: 64] = 64'(data_base) + 64'(i);
    end
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    $display("[TB] start");
    capture_en_i = 1'b1;
    cycle(3);
    check_output("rst_valid", 64'(trace_valid_o), 64'd0);
    check_output("rst_level", 64'(level_o), 64'd0);
    check_output("rst_drop", 64'(drop_cnt_o), 64'd0);
    check_output("rst_ovf", 64'(overflow_o), 64'd0);
    check_output("rst_data", trace_data_o, 64'd0);
    check_output("rst_pc", 64'(trace_pc_o), 64'd0);
    rstn_i = 1'b1;
    cycle(2);

    // Single event with consumer ready
    trace_ready_i = 1'b1;
    apply_stimulus(4'b0001, 4'b0000, 32'h80, 8'h00);
    ev_addr_i[4:0]  = 5'd3;
    ev_data_i[63:0] = 64'h1234;
    exp_ts = tb_ts;
    cycle();
    ev_en_i = '0;
    check_output("t1_valid", 64'(trace_valid_o), 64'd1);
    check_output("t1_addr", 64'(trace_addr_o), 64'd3);
    check_output("t1_data", trace_data_o, 64'h1234);
    check_output("t1_pc", 64'(trace_pc_o), 64'h80);
    check_output("t1_ch", 64'(trace_ch_o), 64'd0);
    check_output("t1_fp", 64'(trace_fp_o), 64'd0);
    check_output("t1_ts", 64'(trace_ts_o), 64'(exp_ts));
    check_output("t1_level", 64'(level_o), 64'd1);
    cycle();
    check_output("t1_popped_level", 64'(level_o), 64'd0);
    check_output("t1_popped_valid", 64'(trace_valid_o), 64'd0);

    // Four events in one cycle, drained in channel order
    trace_ready_i = 1'b0;
    apply_stimulus(4'b1111, 4'b0100, 32'h100, 8'h40);
    exp_ts = tb_ts;
    cycle();
    ev_en_i = '0;
    check_output("t2_level", 64'(level_o), 64'd4);
    cycle(2);
    check_output("t2_hold_ch", 64'(trace_ch_o), 64'd0);
    check_output("t2_hold_level", 64'(level_o), 64'd4);
    trace_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("t2_ch%0d", k), 64'(trace_ch_o), 64'(k));
      check_output($sformatf("t2_addr%0d", k), 64'(trace_addr_o), 64'(k + 1));
      check_output($sformatf("t2_data%0d", k), trace_data_o, 64'h40 + 64'(k));
      check_output($sformatf("t2_fp%0d", k), 64'(trace_fp_o), (k == 2) ? 64'd1 : 64'd0);
      check_output($sformatf("t2_pc%0d", k), 64'(trace_pc_o), 64'h100);
      check_output($sformatf("t2_ts%0d", k), 64'(trace_ts_o), 64'(exp_ts));
      cycle();
    end
    check_output("t2_empty", 64'(trace_valid_o), 64'd0);
    trace_ready_i = 1'b0;

    // capture_en low ignores events
    capture_en_i = 1'b0;
    apply_stimulus(4'b1111, 4'b0000, 32'h200, 8'h00);
    cycle();
    check_output("cap_off_level", 64'(level_o), 64'd0);
    capture_en_i = 1'b1;

    // Fill to 14, atomic drop of 4, then accept 2 to reach full
    apply_stimulus(4'b1111, 4'b0000, 32'h300, 8'h10);
    cycle(3);
    apply_stimulus(4'b0011, 4'b0000, 32'h304, 8'h20);
    cycle();
    ev_en_i = '0;
    check_output("t3_level14", 64'(level_o), 64'd14);
    apply_stimulus(4'b1111, 4'b0000, 32'h308, 8'h30);
    cycle();
    ev_en_i = '0;
    check_output("t3_drop_level", 64'(level_o), 64'd14);
    check_output("t3_drop_cnt", 64'(drop_cnt_o), 64'd4);
    check_output("t3_ovf", 64'(overflow_o), 64'd1);
    apply_stimulus(4'b0110, 4'b0000, 32'h30c, 8'h38);
    cycle();
    ev_en_i = '0;
    check_output("t3_full", 64'(level_o), 64'd16);
    check_output("t3_full_drop", 64'(drop_cnt_o), 64'd4);

    // Full FIFO, pop and push in the same cycle: push dropped
    trace_ready_i = 1'b1;
    apply_stimulus(4'b1000, 4'b0000, 32'h310, 8'h50);
    cycle();
    ev_en_i = '0;
    trace_ready_i = 1'b0;
    check_output("t4_level", 64'(level_o), 64'd15);
    check_output("t4_drop", 64'(drop_cnt_o), 64'd5);
    check_output("t4_head_addr", 64'(trace_addr_o), 64'd2);
    check_output("t4_head_pc", 64'(trace_pc_o), 64'h300);

    // Drain to 9, then clear with a simultaneous push
    trace_ready_i = 1'b1;
    cycle(6);
    trace_ready_i = 1'b0;
    check_output("t5_level9", 64'(level_o), 64'd9);
    check_output("t5_ovf_pre", 64'(overflow_o), 64'd1);
    clear_i = 1'b1;
    trace_ready_i = 1'b1;
    apply_stimulus(4'b0001, 4'b0000, 32'h400, 8'h60);
    cycle();
    clear_i = 1'b0;
    ev_en_i = '0;
    trace_ready_i = 1'b0;
    check_output("t5_level", 64'(level_o), 64'd0);
    check_output("t5_valid", 64'(trace_valid_o), 64'd0);
    check_output("t5_drop", 64'(drop_cnt_o), 64'd0);
    check_output("t5_ovf", 64'(overflow_o), 64'd0);
    cycle(3);
    apply_stimulus(4'b0100, 4'b0000, 32'h500, 8'h70);
    exp_ts = tb_ts;
    cycle();
    ev_en_i = '0;
    check_output("t5_post_level", 64'(level_o), 64'd1);
    check_output("t5_post_ts", 64'(trace_ts_o), 64'(exp_ts));
    check_output("t5_post_ch", 64'(trace_ch_o), 64'd2);
    check_output("t5_post_data", trace_data_o, 64'h72);
    trace_ready_i = 1'b1;
    cycle();
    trace_ready_i = 1'b0;
    check_output("t5_post_empty", 64'(level_o), 64'd0);

    // Int x0 and fp f0 in the same cycle
    apply_stimulus(4'b0011, 4'b0010, 32'h600, 8'h80);
    ev_addr_i[9:0] = '0;
    cycle();
    ev_en_i = '0;
`ifdef RF_TRACE_FILTER_X0_EN
    check_output("t6_level", 64'(level_o), 64'd1);
    check_output("t6_ch", 64'(trace_ch_o), 64'd1);
    check_output("t6_fp", 64'(trace_fp_o), 64'd1);
    check_output("t6_data", trace_data_o, 64'h81);
`else
    check_output("t6_level", 64'(level_o), 64'd2);
    check_output("t6_ch", 64'(trace_ch_o), 64'd0);
    check_output("t6_fp", 64'(trace_fp_o), 64'd0);
    check_output("t6_data", trace_data_o, 64'h80);
`endif
    check_output("t6_addr", 64'(trace_addr_o), 64'd0);
    check_output("t6_drop", 64'(drop_cnt_o), 64'd0);

    // Reset mid-operation discards stored events
    #2 rstn_i = 1'b0;
    #1;
    check_output("rst_mid_level", 64'(level_o), 64'd0);
    check_output("rst_mid_valid", 64'(trace_valid_o), 64'd0);
    check_output("rst_mid_ts", 64'(trace_ts_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
